// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and
// a RUN/FAULT FSM for misaligned redirects and out-of-range fetches.
module instruction_fetch #(
  parameter int DATA_BITS = 32,
  parameter int IMEM_SIZE = 128,
  parameter logic [DATA_BITS-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [DATA_BITS-1:0] branch_target,
  input  logic                 jump,
  input  logic [DATA_BITS-1:0] jump_target,
  output logic [DATA_BITS-1:0] imem_index,
  input  logic [DATA_BITS-1:0] imem_instruction,
  output logic [DATA_BITS-1:0] if_id_instruction,
  output logic [DATA_BITS-1:0] if_id_pc_plus4,
  output logic                 if_id_valid,
  output logic [DATA_BITS-1:0] pc,
  output logic                 fetch_fault
);

  typedef enum logic {
    RUN,
    FAULT
  } state_t;

  localparam logic [DATA_BITS-1:0] IMEM_WORDS =
    DATA_BITS'(IMEM_SIZE);

  state_t               state;
  state_t               state_n;
  logic [DATA_BITS-1:0] pc_n;
  logic [DATA_BITS-1:0] instr_n;
  logic [DATA_BITS-1:0] pp4_n;
  logic                 valid_n;
  logic [DATA_BITS-1:0] pc_plus4;
  logic [DATA_BITS-1:0] target;
  logic                 redirect;
  logic                 oob;

  assign imem_index  = {2'b00, pc[DATA_BITS-1:2]};
  assign pc_plus4    = pc + DATA_BITS'(4);
  assign redirect    = branch_taken | jump;
  assign target      = branch_taken ? branch_target : jump_target;
  assign oob         = (imem_index >= IMEM_WORDS);
  assign fetch_fault = (state == FAULT);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = if_id_instruction;
    pp4_n   = if_id_pc_plus4;
    valid_n = if_id_valid;
    if (state == FAULT) begin
      instr_n = '0;
      valid_n = 1'b0;
    end else if (redirect) begin
      instr_n = '0;
      valid_n = 1'b0;
      // misaligned target never reaches the PC
      if (target[1:0] != 2'b00) state_n = FAULT;
      else pc_n = target;
    end else if (oob) begin
      state_n = FAULT;
      instr_n = '0;
      valid_n = 1'b0;
    end else if (!stall) begin
      pc_n    = pc_plus4;
      instr_n = imem_instruction;
      pp4_n   = pc_plus4;
      valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RUN;
      pc                <= RESET_PC;
      if_id_instruction <= '0;
      if_id_pc_plus4    <= '0;
      if_id_valid       <= 1'b0;
    end else begin
      state             <= state_n;
      pc                <= pc_n;
      if_id_instruction <= instr_n;
      if_id_pc_plus4    <= pp4_n;
      if_id_valid       <= valid_n;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural
// combinational instruction memory.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_index;
  logic [31:0] imem_instruction;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] pc;
  logic        fetch_fault;

  logic [31:0] mem [0:127];
  int total;
  int bad;

  instruction_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump              (jump),
    .jump_target       (jump_target),
    .imem_index        (imem_index),
    .imem_instruction  (imem_instruction),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .pc                (pc),
    .fetch_fault       (fetch_fault)
  );

  assign imem_instruction =
    (imem_index < 32'd128) ? mem[imem_index[6:0]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (pc !== 32'h0) begin
      bad++; $display("FAIL reset_pc got=%h exp=0", pc);
    end
    total++;
    if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 ||
        if_id_pc_plus4 !== 32'h0 || fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL reset_ifid got v=%b i=%h p=%h f=%b exp 0",
               if_id_valid, if_id_instruction, if_id_pc_plus4,
               fetch_fault);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] ei [4];
    ei = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (if_id_instruction !== ei[i] ||
          if_id_pc_plus4 !== 32'(4 * (i + 1)) ||
          if_id_valid !== 1'b1) begin
        bad++;
        $display("FAIL free_run[%0d] got i=%h p=%h v=%b exp i=%h p=%h v=1",
                 i, if_id_instruction, if_id_pc_plus4, if_id_valid,
                 ei[i], 4 * (i + 1));
      end
    end
    total++;
    if (pc !== 32'd16) begin
      bad++; $display("FAIL free_run_pc got=%h exp=10", pc);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (pc !== 32'd8 || if_id_instruction !== 32'hC0DE0001 ||
          if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'd8) begin
        bad++;
        $display("FAIL stall[%0d] got pc=%h i=%h v=%b exp pc=8 i=c0de0001 v=1",
                 i, pc, if_id_instruction, if_id_valid);
      end
    end
    stall = 0;
    step();
    total++;
    if (if_id_instruction !== 32'hC0DE0002 || pc !== 32'd12) begin
      bad++;
      $display("FAIL stall_release got i=%h pc=%h exp i=c0de0002 pc=c",
               if_id_instruction, pc);
    end
  endtask

  task automatic test_redirect();
    stall = 1; branch_taken = 1; jump = 1;
    branch_target = 32'h40; jump_target = 32'h80;
    step();
    idle();
    total++;
    if (pc !== 32'h40 || if_id_valid !== 1'b0 ||
        if_id_instruction !== 32'h0) begin
      bad++;
      $display("FAIL redirect_prio got pc=%h v=%b i=%h exp pc=40 v=0 i=0",
               pc, if_id_valid, if_id_instruction);
    end
    step();
    total++;
    if (if_id_instruction !== 32'hC0DE0010 ||
        if_id_pc_plus4 !== 32'h44 || if_id_valid !== 1'b1) begin
      bad++;
      $display("FAIL redirect_fetch got i=%h p=%h v=%b exp i=c0de0010 p=44 v=1",
               if_id_instruction, if_id_pc_plus4, if_id_valid);
    end
    jump = 1; jump_target = 32'h100;
    step();
    idle();
    step();
    total++;
    if (if_id_instruction !== 32'hC0DE0040 || pc !== 32'h104) begin
      bad++;
      $display("FAIL jump_only got i=%h pc=%h exp i=c0de0040 pc=104",
               if_id_instruction, pc);
    end
  endtask

  task automatic test_misaligned();
    jump = 1; jump_target = 32'h42;
    step();
    idle();
    total++;
    if (fetch_fault !== 1'b1 || pc !== 32'h104 ||
        if_id_valid !== 1'b0 || if_id_instruction !== 32'h0) begin
      bad++;
      $display("FAIL misalign got f=%b pc=%h v=%b i=%h exp f=1 pc=104 v=0 i=0",
               fetch_fault, pc, if_id_valid, if_id_instruction);
    end
    branch_taken = 1; branch_target = 32'h40; stall = 1;
    step();
    idle();
    step();
    total++;
    if (fetch_fault !== 1'b1 || pc !== 32'h104 || if_id_valid !== 1'b0) begin
      bad++;
      $display("FAIL fault_hold got f=%b pc=%h v=%b exp f=1 pc=104 v=0",
               fetch_fault, pc, if_id_valid);
    end
    do_reset();
    total++;
    if (pc !== 32'h0 || fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL fault_reset got pc=%h f=%b exp pc=0 f=0",
               pc, fetch_fault);
    end
    branch_taken = 1; branch_target = 32'h41;
    jump = 1; jump_target = 32'h80;
    step();
    idle();
    total++;
    if (fetch_fault !== 1'b1 || pc !== 32'h0) begin
      bad++;
      $display("FAIL branch_misalign got f=%b pc=%h exp f=1 pc=0",
               fetch_fault, pc);
    end
    do_reset();
  endtask

  task automatic test_oob();
    jump = 1; jump_target = 32'h1F8;
    step();
    idle();
    step(); step();
    total++;
    if (if_id_instruction !== 32'hC0DE007F || pc !== 32'h200 ||
        fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL last_word got i=%h pc=%h f=%b exp i=c0de007f pc=200 f=0",
               if_id_instruction, pc, fetch_fault);
    end
    step();
    total++;
    if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0 ||
        if_id_instruction !== 32'h0 || pc !== 32'h200 ||
        if_id_pc_plus4 !== 32'h200) begin
      bad++;
      $display("FAIL oob got f=%b v=%b i=%h pc=%h p=%h exp f=1 v=0 i=0 pc=200 p=200",
               fetch_fault, if_id_valid, if_id_instruction, pc,
               if_id_pc_plus4);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 7; i++) step();
    total++;
    if (pc !== 32'h1C) begin
      bad++; $display("FAIL pre_stall_pc got=%h exp=1c", pc);
    end
    stall = 1; rst = 1;
    step();
    rst = 0; stall = 0;
    total++;
    if (pc !== 32'h0 || if_id_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_stall got pc=%h v=%b f=%b exp pc=0 v=0 f=0",
               pc, if_id_valid, fetch_fault);
    end
    step();
    total++;
    if (if_id_instruction !== 32'hC0DE0000 || if_id_valid !== 1'b1 ||
        if_id_pc_plus4 !== 32'h4) begin
      bad++;
      $display("FAIL first_after_rst got i=%h v=%b p=%h exp i=c0de0000 v=1 p=4",
               if_id_instruction, if_id_valid, if_id_pc_plus4);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    rst = 1;
    idle();
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_misaligned();
    test_oob();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 32, giving the width of the instruction word and of the PC.
REQ-002 The block SHALL have parameter IMEM_SIZE, default 128, giving the instruction memory depth in words.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the byte address loaded into the PC at reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold the PC and the IF/ID register (hazard unit).
REQ-007 branch_taken  input  1  redirect to branch_target.
REQ-008 branch_target  input  DATA_BITS  branch byte address.
REQ-009 jump  input  1  redirect to jump_target.
REQ-010 jump_target  input  DATA_BITS  jump byte address.
REQ-011 imem_index  output  DATA_BITS  word index to instruction memory, combinational {2'b00, pc[DATA_BITS-1:2]}.
REQ-012 imem_instruction  input  DATA_BITS  word returned combinationally by instruction memory for imem_index.
REQ-013 if_id_instruction  output  DATA_BITS  registered fetched instruction.
REQ-014 if_id_pc_plus4  output  DATA_BITS  registered byte address of the fetched instruction + 4.
REQ-015 if_id_valid  output  1  registered; 1 = IF/ID holds a real instruction.
REQ-016 pc  output  DATA_BITS  current fetch byte address.
REQ-017 fetch_fault  output  1  sticky fault flag.

Function
REQ-018 The block SHALL implement a 2-state FSM: RUN, FAULT.
REQ-019 In RUN, the priority on each edge SHALL be: rst > branch_taken > jump > stall > sequential.
REQ-020 Sequential: pc <= pc+4 (modulo 2^DATA_BITS); if_id_instruction <= imem_instruction; if_id_pc_plus4 <= pc+4; if_id_valid <= 1.
REQ-021 Redirect (branch_taken, or jump without branch_taken): pc <= target; if_id_instruction <= 0 (NOP); if_id_valid <= 0.
REQ-022 A redirect SHALL also win over an asserted stall on the same edge.
REQ-023 Stall without redirect: pc, if_id_instruction, if_id_pc_plus4 and if_id_valid SHALL hold their values.
REQ-024 Fetch latency SHALL be one cycle: the word at pc is visible on if_id_instruction after the next rising edge.
REQ-025 A redirect target with target[1:0] != 0 SHALL NOT load the PC; the FSM SHALL enter FAULT and the IF/ID register SHALL be bubbled.
REQ-026 If pc[DATA_BITS-1:2] >= IMEM_SIZE while in RUN and not redirecting, the FSM SHALL enter FAULT on that edge without capturing; if_id_valid <= 0.
REQ-027 In FAULT: fetch_fault = 1; pc holds; if_id_valid = 0; if_id_instruction = 0; stall, branch_taken and jump are ignored; only rst exits.
REQ-028 fetch_fault SHALL be 1 iff the FSM state is FAULT.

Reset
REQ-029 On a rising edge with rst = 1: pc <= RESET_PC; if_id_instruction <= 0; if_id_pc_plus4 <= 0; if_id_valid <= 0; state <= RUN; fetch_fault <= 0.
REQ-030 rst SHALL override every other input, including mid-stall, mid-redirect and in FAULT.
REQ-031 On the first edge after rst deasserts, the word at RESET_PC SHALL be captured with if_id_valid = 1.

Verification
REQ-032 Reset, then free run over mem[0..3] = A,B,C,D -> after edges 1..4: if_id_instruction = A,B,C,D; if_id_pc_plus4 = 4,8,12,16; pc = 16.
REQ-033 stall held 3 cycles with pc = 8 -> pc stays 8, IF/ID holds B with valid = 1; release -> C captured next edge.
REQ-034 branch_taken = 1, stall = 1, jump = 1, branch_target = 0x40, jump_target = 0x80 -> pc = 0x40, if_id_valid = 0, if_id_instruction = 0; the next edge captures mem[16].
REQ-035 jump_target = 0x42 -> fetch_fault = 1, pc unchanged, valid = 0; further stimulus ignored; rst -> pc = 0, fault = 0.
REQ-036 Sequential fetch reaching pc = 4*IMEM_SIZE (0x200) -> FAULT on that edge, no capture, if_id_valid = 0.
REQ-037 rst asserted during a stall at pc = 0x1C -> next edge: pc = RESET_PC, valid = 0, state RUN.
